// File: rtl/stream_serializer_if.sv
// Parallel-in / serial-out handshake bundle for stream_serializer.
// The master side offers words and grants bit slots; the slave side serializes.
interface stream_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             stream_en;
   logic             Stream;
   logic             stream_valid;

   modport master (
      output in_data, in_valid, stream_en,
      input  in_ready, Stream, stream_valid
   );

   modport slave (
      input  in_data, in_valid, stream_en,
      output in_ready, Stream, stream_valid
   );
endinterface

// File: rtl/stream_serializer.sv
// Two-deep word serializer: a shift register feeds the serial stream while a holding
// register absorbs the next word, so consecutive words stream with no bubble.
module stream_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   stream_serializer_if.slave   sif,
   output logic                 busy,
   output logic [7:0]           word_count
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("stream_serializer: WIDTH must be in 2..32");
   end

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic [WIDTH-1:0]   sh_r;
   logic [WIDTH-1:0]   hold_r;
   logic               hold_full_r;
   logic [CNT_W-1:0]   bit_cnt_r;
   logic [7:0]         word_count_r;
   logic               accept_s;
   logic               consume_s;
   logic               last_s;
   logic               stream_valid_s;
   logic               stream_bit_s;

   function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
      if (MSB_FIRST != 0) begin
         return {v[WIDTH-2:0], 1'b0};
      end else begin
         return {1'b0, v[WIDTH-1:1]};
      end
   endfunction

   // handshake qualifiers for the current cycle
   always_comb begin
      accept_s  = sif.in_valid && !hold_full_r;
      consume_s = (state_r == SHIFT) && sif.stream_en;
      last_s    = consume_s && (bit_cnt_r == CNT_W'(WIDTH - 1));
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // next-state logic; SHIFT is kept across word boundaries when another word is ready
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_s = SHIFT;
            else          state_s = IDLE;
         end
         SHIFT: begin
            if (last_s && !hold_full_r && !accept_s) state_s = IDLE;
            else                                      state_s = SHIFT;
         end
         default: state_s = IDLE;
      endcase
   end

   // datapath: shift register, holding register, bit and word counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_r         <= '0;
         hold_r       <= '0;
         hold_full_r  <= 1'b0;
         bit_cnt_r    <= '0;
         word_count_r <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  sh_r      <= sif.in_data;
                  bit_cnt_r <= '0;
               end
            end
            SHIFT: begin
               if (last_s) begin
                  word_count_r <= word_count_r + 8'd1;
                  bit_cnt_r    <= '0;
                  if (hold_full_r) begin
                     sh_r        <= hold_r;
                     hold_full_r <= 1'b0;
                  end else if (accept_s) begin
                     sh_r <= sif.in_data;
                  end else begin
                     sh_r <= '0;
                  end
               end else begin
                  if (consume_s) begin
                     sh_r      <= shift_once(sh_r);
                     bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                  end
                  if (accept_s) begin
                     hold_r      <= sif.in_data;
                     hold_full_r <= 1'b1;
                  end
               end
            end
            default: begin
               sh_r        <= '0;
               hold_full_r <= 1'b0;
               bit_cnt_r   <= '0;
            end
         endcase
      end
   end

   // output decode from registered state
   always_comb begin
      stream_valid_s = 1'b0;
      stream_bit_s   = 1'b0;
      case (state_r)
         IDLE:    stream_valid_s = 1'b0;
         SHIFT:   stream_valid_s = 1'b1;
         default: stream_valid_s = 1'b0;
      endcase
      if (stream_valid_s) begin
         stream_bit_s = (MSB_FIRST != 0) ? sh_r[WIDTH-1] : sh_r[0];
      end else begin
         stream_bit_s = 1'b0;
      end
   end

   assign sif.in_ready     = !hold_full_r;
   assign sif.stream_valid = stream_valid_s;
   assign sif.Stream       = stream_bit_s;
   assign busy             = stream_valid_s || hold_full_r;
   assign word_count       = word_count_r;

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: an MSB-first and an LSB-first instance
// share clock and reset; expected bits are queued at stimulus time and popped per consume.
module tb_stream_serializer;

   logic       clk;
   logic       rst_n;
   logic       busy1;
   logic       busy2;
   logic [7:0] wc1;
   logic [7:0] wc2;
   int         n_checks;
   int         n_fail;
   bit         q1[$];
   bit         q2[$];

   stream_serializer_if #(.WIDTH(8)) sif1 ();
   stream_serializer_if #(.WIDTH(8)) sif2 ();

   stream_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_msb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sif        (sif1.slave),
      .busy       (busy1),
      .word_count (wc1)
   );

   stream_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
      .clk        (clk),
      .rst_n      (rst_n),
      .sif        (sif2.slave),
      .busy       (busy2),
      .word_count (wc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // offer one word once in_ready allows it; expected bits go to the scoreboard
   task automatic send(input int which, input logic [7:0] d);
      int waited = 0;
      while (((which == 1) ? !sif1.in_ready : !sif2.in_ready) && waited < 60) begin
         @(posedge clk); #1;
         waited++;
      end
      n_checks++;
      if (waited >= 60) begin
         n_fail++;
         $display("FAIL send_ready: in_ready still 0 after %0d cycles, expected 1", waited);
      end
      if (which == 1) begin
         sif1.in_data = d; sif1.in_valid = 1'b1;
         for (int i = 7; i >= 0; i--) q1.push_back(d[i]);
      end else begin
         sif2.in_data = d; sif2.in_valid = 1'b1;
         for (int i = 0; i < 8; i++) q2.push_back(d[i]);
      end
      @(posedge clk); #1;
      sif1.in_valid = 1'b0;
      sif2.in_valid = 1'b0;
   endtask

   // scoreboard: pop and compare each consumed bit until both instances drain
   task automatic drain(input int budget, output int maxrun, output logic [31:0] seen1,
                        output logic [31:0] seen2);
      int  run  = 0;
      bit  done = 1'b0;
      bit  e;
      maxrun = 0; seen1 = '0; seen2 = '0;
      for (int c = 0; c < budget && !done; c++) begin
         @(negedge clk);
         if (sif1.stream_valid) begin
            run++;
            if (run > maxrun) maxrun = run;
            if (sif1.stream_en) begin
               n_checks++;
               if (q1.size() == 0) begin
                  n_fail++; $display("FAIL bit_msb: unexpected bit %0b, expected none", sif1.Stream);
               end else begin
                  e = q1.pop_front();
                  if (sif1.Stream !== e) begin
                     n_fail++; $display("FAIL bit_msb: got %0b, expected %0b", sif1.Stream, e);
                  end
                  seen1 = {seen1[30:0], sif1.Stream};
               end
            end
         end else begin
            run = 0;
            n_checks++;
            if (sif1.Stream !== 1'b0) begin
               n_fail++; $display("FAIL idle_stream_msb: got %0b, expected 0", sif1.Stream);
            end
         end
         if (sif2.stream_valid && sif2.stream_en) begin
            n_checks++;
            if (q2.size() == 0) begin
               n_fail++; $display("FAIL bit_lsb: unexpected bit %0b, expected none", sif2.Stream);
            end else begin
               e = q2.pop_front();
               if (sif2.Stream !== e) begin
                  n_fail++; $display("FAIL bit_lsb: got %0b, expected %0b", sif2.Stream, e);
               end
               seen2 = {seen2[30:0], sif2.Stream};
            end
         end
         if (q1.size() == 0 && q2.size() == 0 && !busy1 && !busy2) done = 1'b1;
      end
      n_checks++;
      if (!done) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d/%0d bits left after %0d cycles, expected 0", q1.size(), q2.size(), budget);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sif1.in_valid = 1'b1; sif1.in_data = 8'hFF; sif1.stream_en = 1'b1;
      sif2.in_valid = 1'b0; sif2.in_data = 8'h00; sif2.stream_en = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (sif1.stream_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b, expected 0", sif1.stream_valid); end
      n_checks++; if (sif1.Stream !== 1'b0) begin n_fail++; $display("FAIL rst_stream: got %0b, expected 0", sif1.Stream); end
      n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b, expected 0", busy1); end
      n_checks++; if (sif1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b, expected 1", sif1.in_ready); end
      n_checks++; if (wc1 !== 8'd0) begin n_fail++; $display("FAIL rst_wc: got %0d, expected 0", wc1); end
      n_checks++; if (wc2 !== 8'd0 || sif2.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_lsb: got wc %0d ready %0b, expected 0/1", wc2, sif2.in_ready); end
      @(posedge clk); #1;
      sif1.in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_single_word();
      int run; logic [31:0] s1; logic [31:0] s2;
      fork
         begin
            send(1, 8'hA4);
            n_checks++;
            if (sif1.stream_valid !== 1'b1 || sif1.Stream !== 1'b1) begin
               n_fail++; $display("FAIL latency: got valid %0b bit %0b, expected 1/1", sif1.stream_valid, sif1.Stream);
            end
         end
         drain(40, run, s1, s2);
      join
      n_checks++; if (s1[7:0] !== 8'hA4) begin n_fail++; $display("FAIL single_pattern: got %0h, expected a4", s1[7:0]); end
      n_checks++; if (run !== 8) begin n_fail++; $display("FAIL single_run: got %0d, expected 8", run); end
      n_checks++; if (wc1 !== 8'd1) begin n_fail++; $display("FAIL single_wc: got %0d, expected 1", wc1); end
      n_checks++; if (sif1.stream_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %0b, expected 0", sif1.stream_valid); end
   endtask

   task automatic test_back_to_back();
      int run; logic [31:0] s1; logic [31:0] s2;
      fork
         begin
            send(1, 8'hA4);
            send(1, 8'h29);
            n_checks++;
            if (sif1.in_ready !== 1'b0 || busy1 !== 1'b1) begin
               n_fail++; $display("FAIL b2b_hold: got ready %0b busy %0b, expected 0/1", sif1.in_ready, busy1);
            end
         end
         drain(60, run, s1, s2);
      join
      n_checks++; if (s1[15:0] !== 16'hA429) begin n_fail++; $display("FAIL b2b_pattern: got %0h, expected a429", s1[15:0]); end
      n_checks++; if (run !== 16) begin n_fail++; $display("FAIL b2b_run: got %0d, expected 16", run); end
      n_checks++; if (wc1 !== 8'd3) begin n_fail++; $display("FAIL b2b_wc: got %0d, expected 3", wc1); end
   endtask

   task automatic test_stall();
      int run; logic [31:0] s1; logic [31:0] s2;
      fork
         begin
            send(1, 8'hA4);
            repeat (4) @(posedge clk);
            #1 sif1.stream_en = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               n_checks++;
               if (sif1.stream_valid !== 1'b1 || sif1.Stream !== 1'b0) begin
                  n_fail++; $display("FAIL stall_hold: got valid %0b bit %0b, expected 1/0", sif1.stream_valid, sif1.Stream);
               end
            end
            @(posedge clk); #1;
            sif1.stream_en = 1'b1;
         end
         drain(60, run, s1, s2);
      join
      n_checks++; if (s1[7:0] !== 8'hA4) begin n_fail++; $display("FAIL stall_pattern: got %0h, expected a4", s1[7:0]); end
      n_checks++; if (run !== 11) begin n_fail++; $display("FAIL stall_run: got %0d, expected 11", run); end
      n_checks++; if (wc1 !== 8'd4) begin n_fail++; $display("FAIL stall_wc: got %0d, expected 4", wc1); end
   endtask

   task automatic test_bypass();
      int run; logic [31:0] s1; logic [31:0] s2;
      fork
         begin
            send(1, 8'hC3);
            repeat (7) @(posedge clk);
            #1;
            send(1, 8'h3C);
            n_checks++;
            if (sif1.in_ready !== 1'b1 || sif1.stream_valid !== 1'b1) begin
               n_fail++; $display("FAIL bypass_direct: got ready %0b valid %0b, expected 1/1", sif1.in_ready, sif1.stream_valid);
            end
         end
         drain(60, run, s1, s2);
      join
      n_checks++; if (s1[15:0] !== 16'hC33C) begin n_fail++; $display("FAIL bypass_pattern: got %0h, expected c33c", s1[15:0]); end
      n_checks++; if (run !== 16) begin n_fail++; $display("FAIL bypass_run: got %0d, expected 16", run); end
      n_checks++; if (wc1 !== 8'd6) begin n_fail++; $display("FAIL bypass_wc: got %0d, expected 6", wc1); end
   endtask

   task automatic test_lsb_first();
      int run; logic [31:0] s1; logic [31:0] s2;
      fork
         send(2, 8'h25);
         drain(40, run, s1, s2);
      join
      n_checks++; if (s2[7:0] !== 8'b1010_0100) begin n_fail++; $display("FAIL lsb_pattern: got %0b, expected 10100100", s2[7:0]); end
      n_checks++; if (wc2 !== 8'd1) begin n_fail++; $display("FAIL lsb_wc: got %0d, expected 1", wc2); end
   endtask

   task automatic test_reset_mid();
      int run; logic [31:0] s1; logic [31:0] s2;
      logic [7:0] d;
      send(1, 8'hC3);
      send(1, 8'h5A);
      repeat (4) @(posedge clk);
      #1;
      n_checks++; if (busy1 !== 1'b1 || sif1.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre: got busy %0b ready %0b, expected 1/0", busy1, sif1.in_ready); end
      rst_n = 1'b0;
      #1;
      n_checks++; if (sif1.stream_valid !== 1'b0 || sif1.Stream !== 1'b0) begin n_fail++; $display("FAIL mid_outs: got valid %0b bit %0b, expected 0/0", sif1.stream_valid, sif1.Stream); end
      n_checks++; if (busy1 !== 1'b0 || sif1.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_flags: got busy %0b ready %0b, expected 0/1", busy1, sif1.in_ready); end
      n_checks++; if (wc1 !== 8'd0) begin n_fail++; $display("FAIL mid_wc: got %0d, expected 0", wc1); end
      q1.delete();
      sif1.in_valid = 1'b1; sif1.in_data = 8'hFF;
      @(posedge clk); #1;
      n_checks++; if (sif1.stream_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ignore: got %0b, expected 0", sif1.stream_valid); end
      rst_n = 1'b1;
      d = 8'h96;
      sif1.in_data = d;
      for (int i = 7; i >= 0; i--) q1.push_back(d[i]);
      fork
         begin
            @(posedge clk); #1;
            sif1.in_valid = 1'b0;
            n_checks++;
            if (sif1.stream_valid !== 1'b1 || sif1.Stream !== 1'b1) begin
               n_fail++; $display("FAIL first_accept: got valid %0b bit %0b, expected 1/1", sif1.stream_valid, sif1.Stream);
            end
         end
         drain(40, run, s1, s2);
      join
      n_checks++; if (s1[7:0] !== 8'h96) begin n_fail++; $display("FAIL mid_restart: got %0h, expected 96", s1[7:0]); end
      n_checks++; if (wc1 !== 8'd1) begin n_fail++; $display("FAIL mid_restart_wc: got %0d, expected 1", wc1); end
   endtask

   task automatic test_wrap();
      int run; logic [31:0] s1; logic [31:0] s2;
      @(posedge clk); #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      fork
         begin
            for (int i = 0; i < 255; i++) send(1, 8'($urandom));
         end
         drain(2400, run, s1, s2);
      join
      n_checks++; if (wc1 !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d, expected 255", wc1); end
      n_checks++; if (run !== 2040) begin n_fail++; $display("FAIL wrap_run: got %0d, expected 2040", run); end
      fork
         send(1, 8'h81);
         drain(40, run, s1, s2);
      join
      n_checks++; if (wc1 !== 8'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d, expected 0", wc1); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_stall();
      test_bypass();
      test_lsb_first();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
